// File: rtl/gated_clock_buffer.sv
// Clock distribution stage between the MMCM and the A/V peripheral domains:
// buffered copies of the source clock, a lock-sequenced glitch-free gated clock and an even divider.
module gated_clock_buffer #(
   parameter int unsigned SEQ_LEN = 8,
   parameter int unsigned DIV_N   = 10
) (
   input  logic clk_in1,
   input  logic rst_n,
   input  logic locked,
   input  logic en,
   output logic clk_buf,
   output logic clk_local,
   output logic clk_gated,
   output logic ready,
   output logic clk_div
);

   localparam int unsigned CNT_W = $clog2(DIV_N);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV_N / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_N - 1);

   logic [SEQ_LEN-1:0] seq;
   logic               ce_q;
   logic [CNT_W-1:0]   cnt;

   assign clk_buf   = clk_in1;
   assign clk_local = clk_in1;
   assign ready     = seq[SEQ_LEN-1];

   // The leading stages also act as the synchronizer for the asynchronous locked input.
   always_ff @(posedge clk_in1 or negedge rst_n) begin
      if (!rst_n) begin
         seq <= '0;
      end else begin
         seq <= {seq[SEQ_LEN-2:0], locked};
      end
   end

   // Updating the enable only while the clock is low keeps every gated high phase full width.
   always_ff @(negedge clk_in1 or negedge rst_n) begin
      if (!rst_n) begin
         ce_q <= 1'b0;
      end else begin
         ce_q <= ready & en;
      end
   end

   assign clk_gated = clk_in1 & ce_q;

   always_ff @(posedge clk_in1 or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         clk_div <= 1'b0;
      end else if (!ready) begin
         cnt     <= '0;
         clk_div <= 1'b0;
      end else begin
         cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
         if (cnt == CNT_HALF || cnt == CNT_LAST) begin
            clk_div <= ~clk_div;
         end
      end
   end

endmodule

// File: tb/tb_gated_clock_buffer.sv
// Randomized bench for gated_clock_buffer against a queue-based behavioural model
// of lock sequencing, negedge-updated gating and run-length based division.
module tb_gated_clock_buffer;

   localparam int SEQ_LEN = 8;
   localparam int DIV_N   = 10;

   logic clk_in1;
   logic rst_n;
   logic locked;
   logic en;
   logic clk_buf;
   logic clk_local;
   logic clk_gated;
   logic ready;
   logic clk_div;

   int checks = 0;
   int errors = 0;

   bit lock_hist[$];
   bit m_ready;
   bit m_div;
   bit m_ce;
   int m_run;

   gated_clock_buffer #(
      .SEQ_LEN(SEQ_LEN),
      .DIV_N  (DIV_N)
   ) dut (
      .clk_in1  (clk_in1),
      .rst_n    (rst_n),
      .locked   (locked),
      .en       (en),
      .clk_buf  (clk_buf),
      .clk_local(clk_local),
      .clk_gated(clk_gated),
      .ready    (ready),
      .clk_div  (clk_div)
   );

   initial clk_in1 = 1'b0;
   always #5 clk_in1 = ~clk_in1;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      lock_hist.delete();
      m_ready = 1'b0;
      m_div   = 1'b0;
      m_ce    = 1'b0;
      m_run   = 0;
   endtask

   // ready reflects the locked sample taken SEQ_LEN-1 edges earlier; the divider output
   // depends only on how many consecutive edges have seen ready high.
   task automatic modelPosedge();
      if (!rst_n) begin
         modelReset();
      end else begin
         if (m_ready) m_run++;
         else m_run = 0;
         m_div = m_ready && ((m_run % DIV_N) >= DIV_N / 2);
         lock_hist.push_back(locked);
         if (lock_hist.size() > SEQ_LEN) void'(lock_hist.pop_front());
         m_ready = (lock_hist.size() == SEQ_LEN) ? lock_hist[0] : 1'b0;
      end
   endtask

   // One full input clock cycle: inputs change mid-high-phase, outputs checked in both phases.
   task automatic applyStimulus(input logic lk, input logic e, input logic en_pulse, input logic rst_mid);
      @(posedge clk_in1);
      modelPosedge();
      #1;
      checkOutput("buf_hi", clk_buf, 1'b1);
      checkOutput("local_hi", clk_local, 1'b1);
      checkOutput("ready_hi", ready, m_ready);
      checkOutput("div_hi", clk_div, m_div);
      checkOutput("gated_hi", clk_gated, m_ce);
      #1;
      locked = lk;
      en     = en_pulse ? ~e : e;
      if (rst_mid) begin
         rst_n = 1'b0;
         modelReset();
      end
      #1;
      en = e;
      if (rst_mid) begin
         checkOutput("rst_gated", clk_gated, 1'b0);
         checkOutput("rst_ready", ready, 1'b0);
         checkOutput("rst_div", clk_div, 1'b0);
      end
      #1;
      checkOutput("gated_mid", clk_gated, m_ce);
      @(negedge clk_in1);
      m_ce = rst_n ? (m_ready & en) : 1'b0;
      #1;
      checkOutput("buf_lo", clk_buf, 1'b0);
      checkOutput("local_lo", clk_local, 1'b0);
      checkOutput("gated_lo", clk_gated, 1'b0);
      checkOutput("ready_lo", ready, m_ready);
      checkOutput("div_lo", clk_div, m_div);
   endtask

   task automatic measureLatency(input string tag);
      int lat;
      lat = 0;
      for (int i = 1; i <= 3 * SEQ_LEN && lat == 0; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
         if (ready === 1'b1) lat = i;
      end
      checkOutput(tag, lat, SEQ_LEN);
   endtask

   initial begin
      int first_rise;
      int second_rise;
      int high_cnt;
      int low_cnt;
      int low_pos;
      logic prev_div;

      modelReset();
      rst_n  = 1'b1;
      locked = 1'b1;
      en     = 1'b1;
      #1;
      rst_n = 1'b0;

      $display("[TB] reset hold with locked and en high");
      repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

      rst_n = 1'b1;
      measureLatency("ready_latency");

      $display("[TB] divider period measurement");
      first_rise  = 0;
      second_rise = 0;
      high_cnt    = 0;
      prev_div    = clk_div;
      for (int i = 1; i <= 50; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
         if (clk_div === 1'b1) high_cnt++;
         if (clk_div === 1'b1 && prev_div === 1'b0) begin
            if (first_rise == 0) first_rise = i;
            else if (second_rise == 0) second_rise = i;
         end
         prev_div = clk_div;
      end
      checkOutput("div_first_rise", first_rise, DIV_N / 2);
      checkOutput("div_period", second_rise - first_rise, DIV_N);
      checkOutput("div_high_cycles", high_cnt, 5 * (DIV_N / 2));

      $display("[TB] enable toggling mid-high-phase");
      repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (2) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

      $display("[TB] single-cycle lock glitch");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      low_cnt = 0;
      low_pos = 0;
      for (int i = 1; i <= 12; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
         if (ready === 1'b0) begin
            low_cnt++;
            low_pos = i;
         end
      end
      checkOutput("glitch_hole_len", low_cnt, 1);
      checkOutput("glitch_hole_pos", low_pos, SEQ_LEN);
      repeat (12) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

      $display("[TB] randomized operation");
      for (int i = 0; i < 400; i++) begin
         if (!rst_n) rst_n = 1'b1;
         applyStimulus(logic'($urandom_range(0, 15) != 0),
                       logic'($urandom_range(0, 3) != 0),
                       logic'($urandom_range(0, 3) == 0),
                       logic'($urandom_range(0, 99) == 0));
      end
      if (!rst_n) rst_n = 1'b1;

      $display("[TB] asynchronous reset mid divider period");
      repeat (SEQ_LEN + 3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      rst_n = 1'b1;
      measureLatency("ready_relatency");
      repeat (DIV_N + 2) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
